// File: rtl/wptr_full_ctrl_pkg.sv
// Shared helpers for the write- and read-side FIFO pointer controllers:
// address-width derivation and Gray/binary conversion.
package wptr_full_ctrl_pkg;

    function automatic int unsigned calc_aw(input int unsigned depth);
        return $clog2(depth);
    endfunction

    // Callers zero-extend into 32 bits and cast the result back to their width.
    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b[31] = g[31];
        for (int i = 30; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/sync_nff.sv
// N-stage flop synchronizer for a multi-bit Gray-coded bus; async active-low reset.
module sync_nff #(
    parameter int unsigned WIDTH  = 1,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [STAGES*WIDTH-1:0] chain_q;
    logic [STAGES*WIDTH-1:0] chain_d;

    // Stage 0 sits in the low slice; the oldest sample is in the top slice.
    always_comb begin
        chain_d = {chain_q[(STAGES-1)*WIDTH-1:0], d_i};
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            chain_q <= '0;
        end else begin
            chain_q <= chain_d;
        end
    end

    assign q_o = chain_q[STAGES*WIDTH-1 -: WIDTH];

endmodule

// File: rtl/wptr_full_ctrl.sv
// Write-side pointer and full/level controller for an asynchronous FIFO.
// All flags are computed from next-state pointers and registered, so they are glitch-free.
module wptr_full_ctrl
    import wptr_full_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH       = 1024,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned AF_LEVEL    = DEPTH - 4,
    localparam int unsigned AW         = calc_aw(DEPTH)
) (
    input  logic          clk_w,
    input  logic          rst_w,
    input  logic          wrt_enable,
    input  logic [AW:0]   rptr_gray_async,
    input  logic          clr_ovf,
    output logic          wrt_en,
    output logic [AW-1:0] waddr,
    output logic [AW:0]   wptr_gray,
    output logic          full,
    output logic          almost_full,
    output logic [AW:0]   wr_level,
    output logic          overflow
);

    localparam logic [AW:0] AfThr = (AW+1)'(AF_LEVEL);

    logic [AW:0] rq;
    logic [AW:0] rbin;
    logic [AW:0] full_target;
    logic [AW:0] wbin_q, wbin_d;
    logic [AW:0] wgray_q, wgray_d;
    logic [AW:0] level_q, level_d;
    logic        full_q, full_d;
    logic        af_q, af_d;
    logic        ovf_q, ovf_d;
    logic        wen;

    sync_nff #(
        .WIDTH  (AW + 1),
        .STAGES (SYNC_STAGES)
    ) u_rptr_sync (
        .clk_i  (clk_w),
        .rst_ni (rst_w),
        .d_i    (rptr_gray_async),
        .q_o    (rq)
    );

    always_comb begin
        wen         = wrt_enable & ~full_q;
        wbin_d      = wbin_q + {{AW{1'b0}}, wen};
        wgray_d     = (AW+1)'(bin2gray(32'(wbin_d)));
        rbin        = (AW+1)'(gray2bin(32'(rq)));
        // Full when the write pointer has lapped the read pointer exactly once.
        full_target = {~rq[AW:AW-1], rq[AW-2:0]};
        level_d     = wbin_d - rbin;
        full_d      = (wgray_d == full_target);
        af_d        = (level_d >= AfThr);
        // A blocked write in the same cycle as a clear keeps the flag set.
        ovf_d       = (ovf_q & ~clr_ovf) | (wrt_enable & full_q);
    end

    always_ff @(posedge clk_w or negedge rst_w) begin
        if (!rst_w) begin
            wbin_q  <= '0;
            wgray_q <= '0;
            level_q <= '0;
            full_q  <= 1'b0;
            af_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            wbin_q  <= wbin_d;
            wgray_q <= wgray_d;
            level_q <= level_d;
            full_q  <= full_d;
            af_q    <= af_d;
            ovf_q   <= ovf_d;
        end
    end

    assign wrt_en      = wen;
    assign waddr       = wbin_q[AW-1:0];
    assign wptr_gray   = wgray_q;
    assign full        = full_q;
    assign almost_full = af_q;
    assign wr_level    = level_q;
    assign overflow    = ovf_q;

endmodule

// File: doc/wptr_full_ctrl.md
WPTR_FULL_CTRL -- requirements
Module: wptr_full_ctrl

Interface
REQ-001 Parameter DEPTH, default 1024, SHALL be FIFO entry count; power of two, >= 4; AW = log2(DEPTH).
REQ-002 Parameter SYNC_STAGES, default 2, SHALL be synchronizer flop count for the read pointer; legal range 2..4.
REQ-003 Parameter AF_LEVEL, default DEPTH-4, SHALL be the almost-full occupancy threshold; legal range 1..DEPTH-1.
REQ-004 clk_w  in  1  write-domain clock; one clock only.
REQ-005 rst_w  in  1  reset, asynchronous, active-low.
REQ-006 wrt_enable  in  1  write request from producer.
REQ-007 rptr_gray_async  in  AW+1  Gray-coded read pointer, driven from the read clock domain.
REQ-008 clr_ovf  in  1  clears the sticky overflow flag.
REQ-009 wrt_en  out  1  qualified write strobe to RAM: wrt_enable AND NOT full.
REQ-010 waddr  out  AW  RAM write address: low AW bits of the binary write pointer.
REQ-011 wptr_gray  out  AW+1  registered Gray write pointer, sent to the read domain.
REQ-012 full  out  1  registered full flag.
REQ-013 almost_full  out  1  registered; high when occupancy >= AF_LEVEL.
REQ-014 wr_level  out  AW+1  registered occupancy as seen by the write side, 0..DEPTH.
REQ-015 overflow  out  1  sticky; set by a write attempt while full.

Function
REQ-016 Binary pointer wbin (AW+1 bits) SHALL increment by 1 on each clk_w edge where wrt_en=1, wrapping modulo 2^(AW+1).
REQ-017 wptr_gray SHALL be registered from wbin_next XOR (wbin_next >> 1), so it changes on the same edge as wbin, with no combinational path to the output.
REQ-018 rptr_gray_async SHALL pass through SYNC_STAGES flops on clk_w; only the final stage (rq) is used internally.
REQ-019 full SHALL be registered from (wgray_next == {~rq[AW:AW-1], rq[AW-2:0]}); full rises on the edge that writes entry DEPTH.
REQ-020 rbin SHALL be the Gray-to-binary conversion of rq; wr_level SHALL be registered from (wbin_next - rbin) modulo 2^(AW+1).
REQ-021 almost_full SHALL be registered from (wbin_next - rbin) >= AF_LEVEL; full implies almost_full.
REQ-022 While full=1, wrt_en SHALL be 0 and the pointers SHALL hold; each wrt_enable=1 cycle SHALL set overflow.
REQ-023 clr_ovf=1 SHALL clear overflow on the next edge; if an overflowing write occurs in the same cycle, set wins.
REQ-024 full, almost_full and wr_level SHALL deassert or decrease only after a read-pointer advance has traversed the synchronizer, i.e. SYNC_STAGES+1 clk_w edges later. Pessimistic flags are acceptable; optimistic flags are forbidden.
REQ-025 Pointer wrap at 2^(AW+1) SHALL be seamless; level and full SHALL stay correct across wrap.

Reset
REQ-026 rst_w low SHALL asynchronously clear wbin, wptr_gray, all synchronizer flops, full, almost_full, wr_level and overflow to 0.
REQ-027 Release SHALL be synchronous to clk_w at the point of use; mid-operation reset SHALL discard all state, and the first write after release SHALL use waddr=0.

Structure
REQ-028 A shared package SHALL hold the functions bin2gray/gray2bin and the AW derivation; the read-side successor reuses them.
REQ-029 Sub-module sync_nff (parametrised width and stage count, async active-low reset) SHALL implement REQ-018; there are no other sub-modules.

Verification
REQ-030 Reset, then wrt_enable=1 for 16 cycles with DEPTH=16 and rptr_gray_async=0 -> waddr 0..15; full=1 after the 16th edge; wr_level=16; almost_full from the 12th edge.
REQ-031 Full FIFO, wrt_enable=1 held for 3 cycles -> wrt_en=0, wbin unchanged, overflow=1; then clr_ovf=1 -> overflow=0 on the next edge.
REQ-032 Full FIFO, rptr_gray_async advanced to gray(1) -> full=0 and wr_level=15 exactly SYNC_STAGES+1 edges later, not earlier.
REQ-033 Random writes and reads with 2^(AW+1)+5 total writes -> wrap correct; wptr_gray differs by one bit per increment; wr_level equals the model every cycle.
REQ-034 Assert rst_w mid-stream at level 9 -> all outputs 0 asynchronously; after release, writes restart at waddr=0.
REQ-035 Simultaneous clr_ovf=1 and a write attempt while full -> overflow remains 1.
